// File: rtl/collision_checker.sv
// Frame-by-frame player/object collision checker with a lives counter and game-over state.
// Define COLLISION_SCORE_EN to enable the survived-frame score counter.
module collision_checker #(
  parameter int unsigned OBJ_SIZE    = 8,
  parameter int unsigned PLAYER_HALF = 16,
  parameter int unsigned LIVES       = 3
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [179:0] objCoordcomb,
  input  logic         imagedone,
  input  logic [8:0]   player_x,
  input  logic [7:0]   player_y,
  input  logic         player_valid,
  input  logic         startgame,
  output logic         gameover,
  output logic         hit,
  output logic [1:0]   lives,
  output logic         busy,
  output logic [7:0]   score
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCAN    = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] OVER    = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         img_q;
  logic [179:0] objs_q, objs_d;
  logic         pv_q, pv_d;
  logic [3:0]   idx_q, idx_d;
  logic [9:0]   cur_mask_q, cur_mask_d;
  logic [9:0]   prev_mask_q, prev_mask_d;
  logic [1:0]   lives_q, lives_d;
  logic         hit_q, hit_d;
  logic         busy_q, busy_d;
  logic         over_q, over_d;

  logic        rise;
  logic [17:0] obj;
  logic [9:0]  ox, oy, px_hi, px_lo, py_hi, py_lo;
  logic        overlap;
  logic [9:0]  new_mask;

  assign rise     = imagedone & ~img_q;
  assign new_mask = cur_mask_q & ~prev_mask_q;

  always_comb begin
    obj = '0;
    for (int i = 0; i < 10; i++) begin
      if (idx_q == 4'(i)) obj = objs_q[18*i +: 18];
    end
  end

  // 10-bit box test; the lower player edge saturates at 0 instead of wrapping.
  always_comb begin
    ox    = {1'b0, obj[8:0]};
    oy    = {2'b0, obj[16:9]};
    px_hi = {1'b0, player_x} + 10'(PLAYER_HALF);
    py_hi = {2'b0, player_y} + 10'(PLAYER_HALF);
    px_lo = ({1'b0, player_x} >= 10'(PLAYER_HALF)) ? {1'b0, player_x} - 10'(PLAYER_HALF) : '0;
    py_lo = ({2'b0, player_y} >= 10'(PLAYER_HALF)) ? {2'b0, player_y} - 10'(PLAYER_HALF) : '0;
    overlap = obj[17] & (ox < px_hi) & ((ox + 10'(OBJ_SIZE)) > px_lo)
                      & (oy < py_hi) & ((oy + 10'(OBJ_SIZE)) > py_lo);
  end

  always_comb begin
    state_d     = state_q;
    objs_d      = objs_q;
    pv_d        = pv_q;
    idx_d       = idx_q;
    cur_mask_d  = cur_mask_q;
    prev_mask_d = prev_mask_q;
    lives_d     = lives_q;
    hit_d       = 1'b0;
    busy_d      = busy_q;
    over_d      = over_q;
    if (startgame) begin
      lives_d     = 2'(LIVES);
      prev_mask_d = '0;
      over_d      = 1'b0;
      busy_d      = 1'b0;
      state_d     = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            objs_d  = objCoordcomb;
            pv_d    = player_valid;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = SCAN;
          end
        end
        SCAN: begin
          for (int i = 0; i < 10; i++) begin
            if (idx_q == 4'(i)) cur_mask_d[i] = pv_q & overlap;
          end
          if (idx_q == 4'd9) state_d = RESOLVE;
          else               idx_d   = idx_q + 4'd1;
        end
        RESOLVE: begin
          prev_mask_d = cur_mask_q;
          busy_d      = 1'b0;
          state_d     = IDLE;
          if (new_mask != '0) begin
            hit_d = 1'b1;
            // One life per frame however many objects are newly hit.
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            if (lives_d == 2'd0) begin
              over_d  = 1'b1;
              state_d = OVER;
            end
          end
        end
        OVER: over_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      img_q       <= 1'b0;
      objs_q      <= '0;
      pv_q        <= 1'b0;
      idx_q       <= '0;
      cur_mask_q  <= '0;
      prev_mask_q <= '0;
      lives_q     <= 2'(LIVES);
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      img_q       <= imagedone;
      objs_q      <= objs_d;
      pv_q        <= pv_d;
      idx_q       <= idx_d;
      cur_mask_q  <= cur_mask_d;
      prev_mask_q <= prev_mask_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      busy_q      <= busy_d;
      over_q      <= over_d;
    end
  end

`ifdef COLLISION_SCORE_EN
  logic [7:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (startgame) begin
      score_d = '0;
    end else if (state_q == RESOLVE && new_mask == '0 && score_q != 8'hFF) begin
      score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) score_q <= '0;
    else        score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

  assign gameover = over_q;
  assign hit      = hit_q;
  assign lives    = lives_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_collision_checker.sv
// Scoreboard bench for collision_checker: directed frames plus randomized frames against a
// box-overlap reference model; results are checked whenever busy falls.
module tb_collision_checker;

  localparam int OS = 8;
  localparam int PH = 16;
  localparam int LV = 3;

  logic         CLOCK_50;
  logic         reset;
  logic [179:0] objCoordcomb;
  logic         imagedone;
  logic [8:0]   player_x;
  logic [7:0]   player_y;
  logic         player_valid;
  logic         startgame;
  logic         gameover;
  logic         hit;
  logic [1:0]   lives;
  logic         busy;
  logic [7:0]   score;

  collision_checker #(
    .OBJ_SIZE   (OS),
    .PLAYER_HALF(PH),
    .LIVES      (LV)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .objCoordcomb(objCoordcomb),
    .imagedone   (imagedone),
    .player_x    (player_x),
    .player_y    (player_y),
    .player_valid(player_valid),
    .startgame   (startgame),
    .gameover    (gameover),
    .hit         (hit),
    .lives       (lives),
    .busy        (busy),
    .score       (score)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic       hit;
    logic [1:0] lives;
    logic       over;
    logic [7:0] score;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  int       o_en[10];
  int       o_x[10];
  int       o_y[10];
  int       px, py;
  bit       pv;
  int       m_lives;
  bit       m_over;
  bit [9:0] m_prev;
  int       m_score;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit ovl(input int i);
    int xl, yl;
    xl = (px >= PH) ? px - PH : 0;
    yl = (py >= PH) ? py - PH : 0;
    return (o_en[i] != 0) && (o_x[i] < px + PH) && (o_x[i] + OS > xl)
                          && (o_y[i] < py + PH) && (o_y[i] + OS > yl);
  endfunction

  task automatic model_reset();
    m_lives = LV;
    m_over  = 1'b0;
    m_prev  = '0;
    m_score = 0;
  endtask

  function automatic exp_t cur_exp(input bit h);
    exp_t e;
    e.hit   = h;
    e.lives = 2'(m_lives);
    e.over  = m_over;
`ifdef COLLISION_SCORE_EN
    e.score = 8'(m_score);
`else
    e.score = 8'd0;
`endif
    return e;
  endfunction

  task automatic model_frame(output exp_t e);
    bit [9:0] cur;
    bit       nh;
    for (int i = 0; i < 10; i++) cur[i] = pv && ovl(i);
    nh     = |(cur & ~m_prev);
    m_prev = cur;
    if (nh) begin
      if (m_lives > 0) m_lives--;
      if (m_lives == 0) m_over = 1'b1;
    end else if (m_score < 255) begin
      m_score++;
    end
    e = cur_exp(nh);
  endtask

  task automatic drive();
    for (int i = 0; i < 10; i++)
      objCoordcomb[18*i +: 18] = {o_en[i][0], 8'(o_y[i]), 9'(o_x[i])};
    player_x     = 9'(px);
    player_y     = 8'(py);
    player_valid = pv;
  endtask

  task automatic clear_objs();
    for (int i = 0; i < 10; i++) begin
      o_en[i] = 0;
      o_x[i]  = 0;
      o_y[i]  = 0;
    end
  endtask

  task automatic set_obj(input int i, input int en, input int x, input int y);
    o_en[i] = en;
    o_x[i]  = x;
    o_y[i]  = y;
  endtask

  task automatic start_game();
    startgame = 1'b1;
    @(posedge CLOCK_50); #1;
    startgame = 1'b0;
    model_reset();
  endtask

  // One imagedone rise; glitch toggles imagedone mid-scan to check the rise is dropped.
  task automatic frame(input bit glitch, output int bc);
    exp_t e;
    bit   scan, done, seen;
    drive();
    scan = !m_over;
    if (scan) begin
      model_frame(e);
      exp_q.push_back(e);
    end
    imagedone = 1'b0;
    @(posedge CLOCK_50); #1;
    imagedone = 1'b1;
    bc   = 0;
    done = 1'b0;
    seen = 1'b0;
    if (scan) begin
      for (int k = 0; k < 40 && !done; k++) begin
        @(negedge CLOCK_50);
        if (busy) bc++;
        else if (bc > 0) done = 1'b1;
        if (glitch && k == 3) imagedone = 1'b0;
        if (glitch && k == 4) imagedone = 1'b1;
      end
      if (!done) chk("scan_timeout", 0, 1);
      if (glitch) begin
        for (int k = 0; k < 15; k++) begin
          @(negedge CLOCK_50);
          if (busy) seen = 1'b1;
        end
        chk("rise_during_busy_requeued", int'(seen), 0);
      end
    end else begin
      for (int k = 0; k < 15; k++) begin
        @(negedge CLOCK_50);
        if (busy) seen = 1'b1;
      end
      chk("over_ignores_rise", int'(seen), 0);
      chk("over_gameover_held", int'(gameover), 1);
    end
    @(posedge CLOCK_50); #1;
    imagedone = 1'b0;
  endtask

  // Abort at scan cycle 5 by startgame or by reset.
  task automatic abort(input bit use_reset);
    drive();
    imagedone = 1'b0;
    @(posedge CLOCK_50); #1;
    imagedone = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #1;
    model_reset();
    exp_q.push_back(cur_exp(1'b0));
    if (use_reset) begin
      reset     = 1'b0;
      imagedone = 1'b0;
      @(negedge CLOCK_50);
      chk("reset_abort_busy", int'(busy), 0);
      @(posedge CLOCK_50); #1;
      reset = 1'b1;
    end else begin
      startgame = 1'b1;
      @(posedge CLOCK_50); #1;
      startgame = 1'b0;
      @(negedge CLOCK_50);
      chk("start_abort_busy", int'(busy), 0);
      imagedone = 1'b0;
    end
    @(posedge CLOCK_50); #1;
    chk("abort_lives", int'(lives), LV);
  endtask

  // Monitor: every busy fall ends a scan and must match the oldest expectation.
  initial begin
    exp_t e;
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (busy_prev && !busy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scan_end_unexpected: got hit=%0b lives=%0d, expected no scan", hit, lives);
        end else begin
          e = exp_q.pop_front();
          if ({hit, lives, gameover, score} !== e) begin
            n_fail++;
            $display("FAIL frame_result: got hit=%0b lives=%0d over=%0b score=%0d, expected hit=%0b lives=%0d over=%0b score=%0d (t=%0t)",
                     hit, lives, gameover, score, e.hit, e.lives, e.over, e.score, $time);
          end
        end
      end else if (reset) begin
        n_cmp++;
        if (hit !== 1'b0) begin
          n_fail++;
          $display("FAIL stray_hit: got hit=%0b, expected 0 (t=%0t)", hit, $time);
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    reset        = 1'b0;
    imagedone    = 1'b0;
    startgame    = 1'b0;
    objCoordcomb = '0;
    clear_objs();
    px = 150;
    py = 100;
    pv = 1'b1;
    drive();
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_lives", int'(lives), LV);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_gameover", int'(gameover), 0);
    chk("rst_score", int'(score), 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    @(posedge CLOCK_50); #1;

    // Single hit, then same list again
    set_obj(0, 1, 150, 100);
    frame(1'b0, bc);
    chk("busy_cycles", bc, 11);
    chk("single_hit_lives", int'(lives), 2);
    frame(1'b0, bc);
    chk("repeat_lives", int'(lives), 2);

    // Right-edge boundary
    start_game();
    set_obj(0, 1, 166, 100);
    frame(1'b0, bc);
    chk("edge166_lives", int'(lives), 3);
    set_obj(0, 1, 165, 100);
    frame(1'b0, bc);
    chk("edge165_lives", int'(lives), 2);

    // Three new hits in a row to game over, then restart
    start_game();
    clear_objs();
    set_obj(0, 1, 150, 100);
    frame(1'b0, bc);
    set_obj(1, 1, 145, 95);
    frame(1'b0, bc);
    set_obj(2, 1, 155, 105);
    frame(1'b0, bc);
    chk("gameover_set", int'(gameover), 1);
    chk("gameover_lives", int'(lives), 0);
    frame(1'b0, bc);
    start_game();
    @(negedge CLOCK_50);
    chk("restart_lives", int'(lives), LV);
    chk("restart_gameover", int'(gameover), 0);
    @(posedge CLOCK_50); #1;

    // Disabled object and tracker loss
    clear_objs();
    set_obj(0, 0, 150, 100);
    frame(1'b0, bc);
    set_obj(0, 1, 150, 100);
    frame(1'b0, bc);
    pv = 1'b0;
    frame(1'b0, bc);
    pv = 1'b1;
    frame(1'b0, bc);
    chk("tracker_relock_lives", int'(lives), 1);

    // Aborts and a rise while busy
    abort(1'b0);
    abort(1'b1);
    @(posedge CLOCK_50); #1;
    frame(1'b1, bc);

    // Randomized frames; small player coordinates exercise the saturating lower edge
    for (int f = 0; f < 80; f++) begin
      if (m_over && $urandom_range(0, 1) == 1) start_game();
      px = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 511));
      py = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      pv = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 10; i++) begin
        int x, y;
        x = px + int'($urandom_range(0, 60)) - 30;
        y = py + int'($urandom_range(0, 60)) - 30;
        x = (x < 0) ? 0 : ((x > 511) ? 511 : x);
        y = (y < 0) ? 0 : ((y > 255) ? 255 : y);
        set_obj(i, ($urandom_range(0, 3) == 0) ? 1 : 0, x, y);
      end
      frame((f % 17) == 5, bc);
    end

    repeat (3) @(posedge CLOCK_50);
    chk("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_checker.md
COLLISION_CHECKER -- requirements
Module: collision_checker

Interface
REQ-001 Parameter OBJ_SIZE, default 8, is the object box edge in pixels.
REQ-002 Parameter PLAYER_HALF, default 16, is the player box half-width and half-height in pixels.
REQ-003 Parameter LIVES, default 3 (range 1..3), is the number of lives per game.
REQ-004 CLOCK_50  in  1  system clock; all state is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 objCoordcomb  in  180  ten 18-bit objects; object i is bits [18i+17:18i], with bit17 enable, [16:9] y, [8:0] x.
REQ-007 imagedone  in  1  high while the object list is stable; a low-to-high transition requests a scan.
REQ-008 player_x  in  9  tracked player centre x.
REQ-009 player_y  in  8  tracked player centre y.
REQ-010 player_valid  in  1  tracker lock indicator.
REQ-011 startgame  in  1  starts a new game.
REQ-012 gameover  out  1  level signal, high when lives are exhausted.
REQ-013 hit  out  1  one-cycle pulse on each new collision.
REQ-014 lives  out  2  remaining lives.
REQ-015 busy  out  1  high while a scan is in progress.
REQ-016 score  out  8  count of frames survived without a hit.

Function
REQ-017 The FSM SHALL have four states: IDLE, SCAN, RESOLVE and OVER.
REQ-018 IDLE: on a detected imagedone rise (registered previous value 0, current value 1), the block SHALL snapshot objCoordcomb and player_valid, set index=0, raise busy and enter SCAN.
REQ-019 SCAN: the block SHALL test one object per cycle, index 0..9, writing cur_mask[index]; after index 9 it SHALL enter RESOLVE.
REQ-020 Object i SHALL be counted as overlapping when all of the following hold:
- enable=1;
- x < player_x+PLAYER_HALF and x+OBJ_SIZE > player_x-PLAYER_HALF;
- y < player_y+PLAYER_HALF and y+OBJ_SIZE > player_y-PLAYER_HALF.
REQ-021 All overlap comparisons SHALL use 10-bit unsigned arithmetic, and each player_?-PLAYER_HALF term SHALL saturate at 0.
REQ-022 If the snapshotted player_valid is 0, cur_mask SHALL be forced to all zeros.
REQ-023 RESOLVE, new-hit case: new = cur_mask & ~prev_mask; if new != 0, hit SHALL pulse for one cycle and lives SHALL decrement by exactly 1, regardless of how many bits are set in new.
REQ-024 RESOLVE, common actions: prev_mask SHALL be loaded with cur_mask, and busy SHALL drop.
REQ-025 RESOLVE, exit: next state SHALL be OVER if lives becomes 0, otherwise IDLE.
REQ-026 Timing: if the rise is sampled in cycle 0, SCAN occupies cycles 1..10, RESOLVE occupies cycle 11, and hit, lives and busy update at the cycle-12 edge.
REQ-027 An imagedone rise while busy SHALL be ignored and not queued.
REQ-028 OVER: gameover SHALL be held at 1 and imagedone SHALL be ignored until startgame=1.
REQ-029 startgame=1 in any state SHALL take priority, in the same cycle:
- lives reloaded to LIVES;
- prev_mask and score cleared;
- gameover, busy and hit set to 0;
- next state IDLE, aborting any in-progress scan.
REQ-030 lives SHALL never decrement below 0.

Reset
REQ-031 While reset=0, the block SHALL force the following:
- state IDLE;
- gameover=0, hit=0, busy=0;
- lives=LIVES, score=0;
- prev_mask=0, cur_mask=0, index=0;
- imagedone edge register=0.
REQ-032 Reset SHALL take effect immediately, mid-scan included, and operation SHALL resume on the first CLOCK_50 edge after reset returns to 1.

Configuration
REQ-033 With macro COLLISION_SCORE_EN defined, score SHALL increment by 1 in each RESOLVE cycle with new=0, saturating at 255.
REQ-034 With COLLISION_SCORE_EN undefined, score SHALL be driven constant 0, no score register SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-035 Single hit: obj0 enable=1, y=100, x=150; player (150,100); player_valid=1; imagedone rise -> busy high for cycles 1..11, hit=1 at cycle 12 only, lives 3->2.
REQ-036 Same list with a second imagedone rise -> no hit, lives stays 2; with COLLISION_SCORE_EN, score increments to 1.
REQ-037 Boundary: obj0 x=166 (player_x+16), otherwise as REQ-035 -> no hit; obj0 x=165 -> hit.
REQ-038 Multi-hit and game over: obj0..obj2 all overlapping, new each frame for three frames -> lives 3->2->1->0, exactly one hit per frame, gameover=1 after the third RESOLVE; further rises ignored; startgame pulse -> lives=3, gameover=0.
REQ-039 Disabled objects and tracker loss:
- enable=0 on an overlapping object -> no hit;
- player_valid=0 with an overlapping object -> no hit, prev_mask cleared;
- player_valid then back to 1 with the same object -> hit.
REQ-040 Abort and reset: startgame or reset asserted at cycle 5 of a scan -> busy=0 next cycle, no hit, lives=3; a rise during busy produces no second scan.
